// File: rtl/axppa_pkg.sv
// Shared definitions for the three-operand adder pipeline.
//   gp_t        : generate/propagate pair used by the Kogge-Stone prefix network
//   clog2       : ceiling log2, usable in constant expressions
//   ks_levels   : prefix levels needed for a WIDTH+2 bit sum
//   ks_groups   : number of registered prefix groups for a given REG_EVERY
//   pipe_stages : register stages after the input register (CSA + groups + output)
package axppa_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int ks_levels(input int width);
    return clog2(width + 2);
  endfunction

  function automatic int ks_groups(input int width, input int reg_every);
    return (ks_levels(width) + reg_every - 1) / reg_every;
  endfunction

  function automatic int pipe_stages(input int width, input int reg_every);
    return ks_groups(width, reg_every) + 2;
  endfunction

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_REG_EVERY = 2;
  localparam int DEF_LEVELS    = ks_levels(DEF_WIDTH);
  localparam int DEF_STAGES    = pipe_stages(DEF_WIDTH, DEF_REG_EVERY);

endpackage

// File: rtl/axppa_three_operand_adder_pipe_if.sv
// Streaming bus of the three-operand adder.
//   in_valid/in_ready   : operand beat handshake (a_input, b_input, c_input, approx_en)
//   out_valid/out_ready : result handshake (sum_output WIDTH+2 bits, out_approx mode tag)
//   master : upstream/downstream side (drives operands, out_ready)
//   slave  : adder side
interface axppa_three_operand_adder_pipe_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic             approx_en;
  logic [WIDTH-1:0] a_input;
  logic [WIDTH-1:0] b_input;
  logic [WIDTH-1:0] c_input;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH+1:0] sum_output;
  logic             out_approx;

  modport master (
    output in_valid, approx_en, a_input, b_input, c_input, out_ready,
    input  in_ready, out_valid, sum_output, out_approx
  );

  modport slave (
    input  in_valid, approx_en, a_input, b_input, c_input, out_ready,
    output in_ready, out_valid, sum_output, out_approx
  );
endinterface

// File: rtl/axppa_ks_prefix_level.sv
// One combinational Kogge-Stone prefix level.
//   gp_in  : group (g,p) pairs from the previous level
//   gp_out : pairs combined with the neighbour DIST bits below
// Bits below DIST already hold their final group value and pass through.
module axppa_ks_prefix_level
  import axppa_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int DIST  = 1
) (
  input  gp_t [WIDTH-1:0] gp_in,
  output gp_t [WIDTH-1:0] gp_out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= DIST) begin : g_op
      assign gp_out[i].g = gp_in[i].g | (gp_in[i].p & gp_in[i-DIST].g);
      assign gp_out[i].p = gp_in[i].p & gp_in[i-DIST].p;
    end else begin : g_pass
      assign gp_out[i] = gp_in[i];
    end
  end

endmodule

// File: rtl/axppa_three_operand_adder_pipe.sv
// Pipelined three-operand adder: CSA 3:2 compression followed by a
// Kogge-Stone prefix adder, with a per-beat lower-part-OR approximate mode.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : slave side of the streaming interface
// Stages: input reg -> CSA reg -> prefix groups (reg every REG_EVERY levels)
// -> output reg. A single global stall freezes every stage together, so
// bubbles stay in place and ordering is trivially preserved.
module axppa_three_operand_adder_pipe
  import axppa_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 4,
  parameter int REG_EVERY   = 2
) (
  input logic clk,
  input logic reset,
  axppa_three_operand_adder_pipe_if.slave bus
);

  localparam int W2     = WIDTH + 2;
  localparam int L      = ks_levels(WIDTH);
  localparam int STAGES = pipe_stages(WIDTH, REG_EVERY);
  localparam logic [W2-1:0] ONE     = W2'(1);
  localparam logic [W2-1:0] LO_MASK = (ONE << APPROX_BITS) - ONE;

  // vld_pipe[0] = input reg, [1] = CSA reg, [2..STAGES-1] = prefix groups,
  // [STAGES] = output reg.
  logic [STAGES:0] vld_pipe;
  logic            stall;
  logic            accept;

  assign stall         = vld_pipe[STAGES] && !bus.out_ready;
  assign bus.in_ready  = reset && !stall;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (!reset)      vld_pipe <= '0;
    else if (!stall) vld_pipe <= {vld_pipe[STAGES-1:0], accept};
  end

  // Input register
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic             ap0_q;

  always_ff @(posedge clk) begin
    if (!stall) begin
      a_q   <= bus.a_input;
      b_q   <= bus.b_input;
      c_q   <= bus.c_input;
      ap0_q <= bus.approx_en;
    end
  end

  // CSA 3:2. In approximate mode the low K sum bits become a|b|c and the
  // low K carries are dropped, which also zeroes the carry into bit K.
  logic [W2-1:0] a_x, b_x, c_x, s_x, cy_x, s_m, cy_m;

  assign a_x  = W2'(a_q);
  assign b_x  = W2'(b_q);
  assign c_x  = W2'(c_q);
  assign s_x  = a_x ^ b_x ^ c_x;
  assign cy_x = (a_x & b_x) | (a_x & c_x) | (b_x & c_x);
  assign s_m  = ap0_q ? ((s_x & ~LO_MASK) | ((a_x | b_x | c_x) & LO_MASK)) : s_x;
  assign cy_m = ap0_q ? (cy_x & ~LO_MASK) : cy_x;

  logic [W2-1:0] s_q, c_q2;
  logic          ap1_q;

  always_ff @(posedge clk) begin
    if (!stall) begin
      s_q   <= s_m;
      c_q2  <= cy_m << 1;
      ap1_q <= ap0_q;
    end
  end

  // Prefix network. lvl_in[j] feeds level j; the half-sum and mode tag ride
  // along so the final XOR sees matching data.
  gp_t  [W2-1:0] gp1;
  gp_t  [W2-1:0] lvl_in [1:L+1];
  logic [W2-1:0] hs_in  [1:L+1];
  logic          ap_in  [1:L+1];

  for (genvar i = 0; i < W2; i++) begin : g_gp
    assign gp1[i].g = s_q[i] & c_q2[i];
    assign gp1[i].p = s_q[i] ^ c_q2[i];
  end

  assign lvl_in[1] = gp1;
  assign hs_in[1]  = s_q ^ c_q2;
  assign ap_in[1]  = ap1_q;

  for (genvar j = 1; j <= L; j++) begin : g_lvl
    gp_t [W2-1:0] gp_c;

    axppa_ks_prefix_level #(.WIDTH(W2), .DIST(1 << (j-1))) u_lvl (
      .gp_in  (lvl_in[j]),
      .gp_out (gp_c)
    );

    if ((j % REG_EVERY == 0) || (j == L)) begin : g_reg
      gp_t  [W2-1:0] gp_q;
      logic [W2-1:0] hs_q;
      logic          ap_q;

      always_ff @(posedge clk) begin
        if (!stall) begin
          gp_q <= gp_c;
          hs_q <= hs_in[j];
          ap_q <= ap_in[j];
        end
      end

      assign lvl_in[j+1] = gp_q;
      assign hs_in[j+1]  = hs_q;
      assign ap_in[j+1]  = ap_q;
    end else begin : g_comb
      assign lvl_in[j+1] = gp_c;
      assign hs_in[j+1]  = hs_in[j];
      assign ap_in[j+1]  = ap_in[j];
    end
  end

  // Final XOR: bit i sums with the group carry out of bits [i-1:0].
  logic [W2-1:0] g_fin, p_fin;
  logic          unused_p;

  for (genvar i = 0; i < W2; i++) begin : g_fin_bit
    assign g_fin[i] = lvl_in[L+1][i].g;
    assign p_fin[i] = lvl_in[L+1][i].p;
  end
  assign unused_p = ^p_fin;

  logic [W2-1:0] sum_q;
  logic          apo_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_q <= '0;
      apo_q <= 1'b0;
    end else if (!stall) begin
      sum_q <= hs_in[L+1] ^ (g_fin << 1);
      apo_q <= ap_in[L+1];
    end
  end

  assign bus.sum_output = sum_q;
  assign bus.out_approx = apo_q;

endmodule

// File: tb/tb_axppa_three_operand_adder_pipe.sv
// Self-checking bench: directed beats with latency checks, randomized
// backpressure streams against a queue-based arithmetic model, and a
// mid-stream reset.
module tb_axppa_three_operand_adder_pipe;
  localparam int WIDTH = 16;
  localparam int K     = 4;
  localparam int W2    = WIDTH + 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  axppa_three_operand_adder_pipe_if #(.WIDTH(WIDTH)) bus ();

  axppa_three_operand_adder_pipe #(.WIDTH(WIDTH), .APPROX_BITS(K), .REG_EVERY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_cons = 0;
  bit mon_en = 1'b0;
  logic [W2:0] exp_q [$];   // {mode, sum}
  logic [W2:0] e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W2-1:0] ref_sum(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c, input logic m);
    int unsigned hi, lo;
    if (!m) return W2'(32'(a) + 32'(b) + 32'(c));
    hi = (32'(a) >> K) + (32'(b) >> K) + (32'(c) >> K);
    lo = 32'(a | b | c) & ((32'd1 << K) - 32'd1);
    return W2'((hi << K) | lo);
  endfunction

  // Scoreboard: record accepted beats, check results in order at consume.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", 32'(bus.in_ready), 32'(reset && !(bus.out_valid && !bus.out_ready)));
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back({bus.approx_en,
                         ref_sum(bus.a_input, bus.b_input, bus.c_input, bus.approx_en)});
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("q_nonempty", 32'(exp_q.size()), 32'd1);
        else begin
          e = exp_q.pop_front();
          chk("sum", 32'(bus.sum_output), 32'(e[W2-1:0]));
          chk("mode", 32'(bus.out_approx), 32'(e[W2]));
          n_cons++;
        end
      end
    end
  end

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                       input logic m);
    bus.a_input   = a;
    bus.b_input   = b;
    bus.c_input   = c;
    bus.approx_en = m;
  endtask

  task automatic beat1(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic m, input logic [W2-1:0] exp);
    drive(a, b, c, m);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk({tag, "_early"}, 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
    end
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(bus.sum_output), 32'(exp));
    chk({tag, "_mode"}, 32'(bus.out_approx), 32'(m));
    @(posedge clk); #1;
  endtask

  task automatic stream(input string tag, input int nres, input bit mixed);
    logic [15:0] a = 16'd5;
    logic [15:0] b = 16'd0;
    logic [15:0] c = 16'd0;
    logic        m = 1'b0;
    bit          acc;
    int          start = n_cons;
    int          guard = 0;
    drive(a, b, c, m);
    bus.in_valid = 1'b1;
    while ((n_cons - start) < nres && guard < 4000) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        a += 16'd1; b += 16'd4; c += 16'd8;
        if (mixed) m = ~m;
        drive(a, b, c, m);
      end
    end
    chk({tag, "_count"}, 32'((n_cons - start) >= nres), 32'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(16'd0, 16'd0, 16'd0, 1'b0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum", 32'(bus.sum_output), 32'd0);
    chk("rst_mode", 32'(bus.out_approx), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    beat1("exact5", 16'd5, 16'd0, 16'd0, 1'b0, 18'h00005);
    beat1("exactmax", 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 18'h2FFFD);
    beat1("approx1", 16'h0018, 16'h0018, 16'h0008, 1'b1, 18'h00028);
    beat1("approx2", 16'h000F, 16'h0001, 16'h0001, 1'b1, 18'h0000F);

    stream("stream", 200, 1'b0);
    stream("mixed", 100, 1'b1);

    // Reset with four beats in flight.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(16'(5 + i), 16'(4 * i), 16'(8 * i), 1'b0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_sum", 32'(bus.sum_output), 32'd0);
    exp_q.delete();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("no_stale", 32'(bus.out_valid), 32'd0);
    end
    beat1("post_rst", 16'd1, 16'd2, 16'd3, 1'b0, 18'h00006);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
